// File: rtl/usb_buffer_pkg.sv
// Shared definitions for the USB packet buffer: buffer geometry, CPU window
// address, length width and the buffer-ownership state encoding.
package usb_buffer_pkg;

  localparam logic [31:0] ADDRESS_USB_PACKET_BUFFER = 32'hc000_0000;
  localparam int          USB_PACKET_BUFFER_SIZE    = 1024;
  localparam int          LEN_W                     = 11;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    RX_READY = 2'd1,
    TX_READY = 2'd2
  } buf_state_e;

endpackage

// File: rtl/usb_packet_ram.sv
// Single-port 32-bit packet RAM with byte write enables and a registered
// (read-first) output, written so that synthesis maps it onto block RAM.
module usb_packet_ram #(
  parameter int AW = 8
) (
  input  logic          clk48,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    wstrb,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];

  // NOTE: no reset on the array or its output register; a reset branch
  // here would stop the tools from mapping the memory onto block RAM.
  always_ff @(posedge clk48) begin
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/usb_buffer_arbiter.sv
// Shares the packet RAM port between CPU and USB engine (USB has priority)
// and tracks buffer ownership through EMPTY / RX_READY / TX_READY.
module usb_buffer_arbiter
  import usb_buffer_pkg::*;
#(
  parameter  int BUFFER_BYTES = USB_PACKET_BUFFER_SIZE,
  localparam int AW           = $clog2(BUFFER_BYTES / 4)
) (
  input  logic             clk48,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [AW-1:0]    cpu_addr,
  input  logic [31:0]      cpu_wdata,
  input  logic [3:0]       cpu_wstrb,
  output logic             cpu_ack,
  output logic [31:0]      cpu_rdata,
  input  logic             usb_req,
  input  logic             usb_we,
  input  logic [AW-1:0]    usb_addr,
  input  logic [31:0]      usb_wdata,
  input  logic [3:0]       usb_wstrb,
  output logic             usb_ack,
  output logic [31:0]      usb_rdata,
  input  logic             usb_packet_done,
  input  logic [LEN_W-1:0] usb_rx_len,
  input  logic             usb_tx_done,
  input  logic             cpu_send,
  input  logic [LEN_W-1:0] cpu_tx_len,
  input  logic             cpu_release,
  output logic             packet_ready,
  output logic             tx_ready,
  output logic [LEN_W-1:0] packet_len,
  output logic             overrun
);

  buf_state_e       state, state_next;
  logic             len_load;
  logic [LEN_W-1:0] len_next;

  logic             usb_grant, cpu_grant, usb_write_blocked;
  logic             cpu_rd_q, usb_rd_q;
  logic [31:0]      cpu_rdata_q, usb_rdata_q;
  logic [AW-1:0]    ram_addr;
  logic [3:0]       ram_wstrb;
  logic [31:0]      ram_wdata, ram_q;

  // A requester whose ack is going out this cycle is not pending any more.
  always_comb begin
    usb_grant         = usb_req && !usb_ack;
    cpu_grant         = cpu_req && !cpu_ack && !usb_grant;
    usb_write_blocked = usb_grant && usb_we && (state != EMPTY);
  end

  // NOTE: every output of this block gets a default before any branch, so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    ram_addr  = cpu_addr;
    ram_wdata = cpu_wdata;
    ram_wstrb = '0;
    if (usb_grant) begin
      ram_addr  = usb_addr;
      ram_wdata = usb_wdata;
      if (usb_we && state == EMPTY) ram_wstrb = usb_wstrb;
    end else if (cpu_grant && cpu_we) begin
      ram_wstrb = cpu_wstrb;
    end
    if (reset) ram_wstrb = '0;
  end

  usb_packet_ram #(.AW(AW)) u_ram (
    .clk48 (clk48),
    .addr  (ram_addr),
    .wstrb (ram_wstrb),
    .wdata (ram_wdata),
    .rdata (ram_q)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk48) begin
    if (reset) begin
      cpu_ack     <= 1'b0;
      usb_ack     <= 1'b0;
      overrun     <= 1'b0;
      cpu_rd_q    <= 1'b0;
      usb_rd_q    <= 1'b0;
      cpu_rdata_q <= '0;
      usb_rdata_q <= '0;
    end else begin
      cpu_ack  <= cpu_grant;
      usb_ack  <= usb_grant;
      overrun  <= usb_write_blocked;
      cpu_rd_q <= cpu_grant && !cpu_we;
      usb_rd_q <= usb_grant && !usb_we;
      if (cpu_rd_q) cpu_rdata_q <= ram_q;
      if (usb_rd_q) usb_rdata_q <= ram_q;
    end
  end

  // Each side sees fresh RAM data only on its own read ack, else its last word.
  assign cpu_rdata = cpu_rd_q ? ram_q : cpu_rdata_q;
  assign usb_rdata = usb_rd_q ? ram_q : usb_rdata_q;

  always_ff @(posedge clk48) begin
    if (reset) begin
      state      <= EMPTY;
      packet_len <= '0;
    end else begin
      state <= state_next;
      if (len_load) packet_len <= len_next;
    end
  end

  // RX completion takes precedence over a simultaneous cpu_send.
  always_comb begin
    state_next = state;
    len_load   = 1'b0;
    len_next   = usb_rx_len;
    case (state)
      EMPTY: begin
        if (usb_packet_done) begin
          state_next = RX_READY;
          len_load   = 1'b1;
        end else if (cpu_send) begin
          state_next = TX_READY;
          len_load   = 1'b1;
          len_next   = cpu_tx_len;
        end
      end
      RX_READY: if (cpu_release) state_next = EMPTY;
      TX_READY: if (usb_tx_done) state_next = EMPTY;
      default:  state_next = EMPTY;
    endcase
  end

  always_comb begin
    packet_ready = (state == RX_READY);
    tx_ready     = (state == TX_READY);
  end

endmodule
